// File: rtl/bwt_pkg.sv
// -----------------------------------------------------------------------------
// bwt_pkg
// Shared types and constants for the cyclic BWT / suffix-array engine.
//   bwt_state_e        : engine FSM states
//   rank_w()           : width of a rank word, max(sym_w, clog2(n))
//   BWT_N_DEFAULT      : default block length
//   BWT_SYM_W_DEFAULT  : default symbol width
// -----------------------------------------------------------------------------
package bwt_pkg;

  localparam int BWT_N_DEFAULT     = 8;
  localparam int BWT_SYM_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RANK,
    COMMIT,
    SCATTER,
    EMIT
  } bwt_state_e;

  // A rank must hold either an initial symbol or a sorted position.
  function automatic int rank_w(input int sym_w, input int n);
    int idx_w;
    idx_w = $clog2(n);
    return (sym_w > idx_w) ? sym_w : idx_w;
  endfunction

endpackage

// File: rtl/bwt_if.sv
// -----------------------------------------------------------------------------
// bwt_if
// Stream and control bundle of bwt_sa_engine.
//   start                : one-cycle start pulse (master -> engine)
//   in_valid/in_ready    : input symbol handshake, in_data index 0 first
//   out_valid/out_ready  : BWT output handshake, out_data / out_last
//   out_primary          : sorted position of rotation 0
//   busy / done          : status, done is a one-cycle completion pulse
// IDX_W must equal $clog2(N) of the engine it is connected to.
// -----------------------------------------------------------------------------
interface bwt_if
  import bwt_pkg::*;
#(
  parameter int SYM_W = BWT_SYM_W_DEFAULT,
  parameter int IDX_W = $clog2(BWT_N_DEFAULT)
) ();

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_data;
  logic             out_last;
  logic [IDX_W-1:0] out_primary;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_primary, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_primary, busy, done
  );

endinterface

// File: rtl/bwt_key_cmp.sv
// -----------------------------------------------------------------------------
// bwt_key_cmp
// Combinational comparator of two {hi, lo} rank pairs.
//   a_hi, a_lo : key A
//   b_hi, b_lo : key B
//   lt         : key A < key B
//   eq         : key A == key B
// -----------------------------------------------------------------------------
module bwt_key_cmp #(
  parameter int RANK_W = 8
) (
  input  logic [RANK_W-1:0] a_hi,
  input  logic [RANK_W-1:0] a_lo,
  input  logic [RANK_W-1:0] b_hi,
  input  logic [RANK_W-1:0] b_lo,
  output logic              lt,
  output logic              eq
);

  assign lt = {a_hi, a_lo} <  {b_hi, b_lo};
  assign eq = {a_hi, a_lo} == {b_hi, b_lo};

endmodule

// File: rtl/bwt_sa_engine.sv
// -----------------------------------------------------------------------------
// bwt_sa_engine
// Cyclic Burrows-Wheeler transform of an N-symbol block. The rotation suffix
// array is built by prefix doubling (one key comparison per cycle), then the
// last column is streamed out in sorted order with the primary index.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bwt_if.slave (start, input stream, output stream, status)
// Build option: BWT_EARLY_EXIT_EN -- stop doubling as soon as a round leaves
// no equal keys. Results are identical; only latency changes.
// Equal rotations (periodic blocks) are ordered by ascending start index.
// -----------------------------------------------------------------------------
module bwt_sa_engine
  import bwt_pkg::*;
#(
  parameter int N     = BWT_N_DEFAULT,
  parameter int SYM_W = BWT_SYM_W_DEFAULT
) (
  input logic  clk,
  input logic  rst_n,
  bwt_if.slave bus
);

  localparam int IDX_W  = $clog2(N);
  localparam int RANK_W = rank_w(SYM_W, N);
  localparam int K_W    = IDX_W + 2;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [RANK_W-1:0] rank_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  if (N < 2) begin : g_bad_n
    $error("bwt_sa_engine: N must be at least 2");
  end

  bwt_state_e       state;
  logic [K_W-1:0]   k;
  idx_t             cnt;
  idx_t             p;
  idx_t             i_idx;
  idx_t             j_idx;
  rank_t            acc;

  logic [SYM_W-1:0] data_mem [N];
  rank_t            rank_mem [N];
  rank_t            nr_mem   [N];
  idx_t             sa_mem   [N];

  // (x + off) mod N; both operands are below N, so one subtract suffices.
  function automatic idx_t wrap_add(input idx_t x, input logic [K_W-1:0] off);
    logic [K_W-1:0] s;
    s = K_W'(x) + off;
    return (s >= K_W'(N)) ? idx_t'(s - K_W'(N)) : idx_t'(s);
  endfunction

  // (x + N - 1) mod N: index of the symbol preceding rotation x.
  function automatic idx_t pred_idx(input idx_t x);
    return (x == '0) ? LAST_IDX : idx_t'(x - 1'b1);
  endfunction

  // ---------------------------------------------------------------------------
  // Ranking datapath: compare key(j) against key(i)
  // ---------------------------------------------------------------------------
  idx_t       i_nxt;
  idx_t       j_nxt;
  idx_t       p_nxt;
  logic       key_lt;
  logic       key_eq;
  logic [K_W:0] k_dbl;
  logic       final_round;
  logic       inc;
  rank_t      acc_nxt;
  logic       early_exit;

  assign i_nxt = wrap_add(i_idx, k);
  assign j_nxt = wrap_add(j_idx, k);
  assign p_nxt = idx_t'(p + 1'b1);

  bwt_key_cmp #(.RANK_W(RANK_W)) u_key_cmp (
    .a_hi (rank_mem[j_idx]),
    .a_lo (rank_mem[j_nxt]),
    .b_hi (rank_mem[i_idx]),
    .b_lo (rank_mem[i_nxt]),
    .lt   (key_lt),
    .eq   (key_eq)
  );

  assign k_dbl       = {k, 1'b0};
  assign final_round = (k_dbl >= (K_W+1)'(N));
  // In the last round equal keys are broken by start index so the ranks
  // become a permutation even for periodic blocks.
  assign inc         = key_lt | (final_round & key_eq & (j_idx < i_idx));
  assign acc_nxt     = acc + rank_t'(inc);

`ifdef BWT_EARLY_EXIT_EN
  logic tie;
  assign early_exit = ~tie;
`else
  assign early_exit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      k               <= '0;
      cnt             <= '0;
      p               <= '0;
      i_idx           <= '0;
      j_idx           <= '0;
      acc             <= '0;
      bus.in_ready    <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_last    <= 1'b0;
      bus.out_primary <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
`ifdef BWT_EARLY_EXIT_EN
      tie             <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            if (cnt == LAST_IDX) begin
              state        <= RANK;
              cnt          <= '0;
              k            <= K_W'(1);
              i_idx        <= '0;
              j_idx        <= '0;
              acc          <= '0;
              bus.in_ready <= 1'b0;
            end else begin
              cnt <= idx_t'(cnt + 1'b1);
            end
          end
        end

        RANK: begin
`ifdef BWT_EARLY_EXIT_EN
          if (key_eq && (j_idx != i_idx)) tie <= 1'b1;
`endif
          if (j_idx == LAST_IDX) begin
            j_idx <= '0;
            acc   <= '0;
            if (i_idx == LAST_IDX) begin
              i_idx <= '0;
              state <= COMMIT;
            end else begin
              i_idx <= idx_t'(i_idx + 1'b1);
            end
          end else begin
            j_idx <= idx_t'(j_idx + 1'b1);
            acc   <= acc_nxt;
          end
        end

        COMMIT: begin
          k <= k << 1;
          if (final_round || early_exit) begin
            state <= SCATTER;
            cnt   <= '0;
          end else begin
            state <= RANK;
`ifdef BWT_EARLY_EXIT_EN
            tie   <= 1'b0;
`endif
          end
        end

        SCATTER: begin
          bus.out_primary <= idx_t'(rank_mem[0]);
          // The rotation landing in sorted slot 0 supplies the first symbol.
          if (rank_mem[cnt] == '0) bus.out_data <= data_mem[pred_idx(cnt)];
          if (cnt == LAST_IDX) begin
            state         <= EMIT;
            cnt           <= '0;
            p             <= '0;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
          end else begin
            cnt <= idx_t'(cnt + 1'b1);
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            if (p == LAST_IDX) begin
              state         <= IDLE;
              p             <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end else begin
              p            <= p_nxt;
              bus.out_data <= data_mem[pred_idx(sa_mem[p_nxt])];
              bus.out_last <= (p_nxt == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register arrays
  // ---------------------------------------------------------------------------
  // NOTE: the arrays carry no reset; every entry is written before it is read
  // in each block, so a reset network on them would buy nothing.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid && bus.in_ready) begin
      data_mem[cnt] <= bus.in_data;
      rank_mem[cnt] <= rank_t'(bus.in_data);
    end
    if (state == RANK && j_idx == LAST_IDX) nr_mem[i_idx] <= acc_nxt;
    if (state == COMMIT) begin
      for (int x = 0; x < N; x++) rank_mem[x] <= nr_mem[x];
    end
    if (state == SCATTER) sa_mem[idx_t'(rank_mem[cnt])] <= cnt;
  end

endmodule
